bus_arbiter: RTL and testbench

Round-robin arbiter for the shared tristate system bus. Grants bus ownership to one of N masters (CPU memory-access units, DMA engines) via a one-hot req/grant handshake. Holds a grant until the owning master withdraws its request, and inserts one idle turnaround cycle between owners to prevent driver overlap. Monitors each tenure for a missing slave acknowledge and latches a sticky timeout error.

---
 rtl/bus_arbiter.sv | 102 ++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared tristate bus, with a one-cycle turnaround gap and a sticky tenure timeout.
// Latency: grant one cycle after a request is seen idle; release to next grant is two edges (one GAP cycle).
// Backpressure: none; an owner keeps the bus until it drops its request, and others are never preempted.
module bus_arbiter #(
   parameter int N = 4,
   parameter int TIMEOUT = 1024,
   localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    bus_req,
   input  logic            fc_bus,
   output logic [N-1:0]    bus_grant,
   output logic            busy,
   output logic [ID_W-1:0] owner_id,
   input  logic            err_clr,
   output logic            err,
   output logic [ID_W-1:0] err_id
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
   localparam logic [15:0] TO_PRE = 16'(TIMEOUT - 1);

   state_t            state;
   logic [15:0]       hold_cnt;
   logic              tout_done;   // timeout already reported in this tenure
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   cand;
   logic [N-1:0]      win_onehot;
   logic              any_req;

   // Round-robin pick: scan owner_id+1 .. owner_id+N (mod N); the smallest offset with a request wins.
   always_comb begin
      win     = owner_id;
      cand    = '0;
      any_req = |bus_req;
      for (int i = N; i >= 1; i--) begin
         cand = ID_W'((int'(owner_id) + i) % N);
         if (bus_req[cand]) win = cand;
      end
   end

   // One-hot image of the selected winner.
   always_comb begin
      win_onehot      = '0;
      win_onehot[win] = 1'b1;
   end

   assign busy = |bus_grant;

   // Arbitration FSM, hold counter and sticky error, all registered; reset drops the grant without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bus_grant <= '0;
         owner_id  <= ID_W'(N - 1);
         hold_cnt  <= '0;
         tout_done <= 1'b0;
         err       <= 1'b0;
         err_id    <= '0;
      end else begin
         // Clear first so that a timeout in the same cycle overrides it.
         if (err_clr) err <= 1'b0;
         case (state)
            IDLE, GAP: begin
               if (any_req) begin
                  bus_grant <= win_onehot;
                  owner_id  <= win;
                  hold_cnt  <= '0;
                  tout_done <= 1'b0;
                  state     <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               if (fc_bus)
                  hold_cnt <= '0;
               else if (hold_cnt != TO_LIM)
                  hold_cnt <= hold_cnt + 16'd1;
               // Fire on the edge where the counter steps onto TIMEOUT, once per tenure.
               if (!fc_bus && hold_cnt == TO_PRE && !tout_done) begin
                  err       <= 1'b1;
                  err_id    <= owner_id;
                  tout_done <= 1'b1;
               end
               if (!bus_req[owner_id]) begin
                  bus_grant <= '0;
                  state     <= GAP;
               end
            end
            default: begin
               bus_grant <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, hand-written corner sequences, randomized run against a tenure model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives all inputs directly.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] bus_req = '0;
   logic       fc_bus = 1'b0;
   logic       err_clr = 1'b0;
   logic [3:0] bus_grant;
   logic       busy;
   logic [1:0] owner_id;
   logic       err;
   logic [1:0] err_id;

   int errs = 0;
   int nchk = 0;

   bus_arbiter #(.N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .bus_req(bus_req), .fc_bus(fc_bus),
      .bus_grant(bus_grant), .busy(busy), .owner_id(owner_id),
      .err_clr(err_clr), .err(err), .err_id(err_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Tenure-level reference: who owns the bus (-1 = nobody), who owned it last, how long since an ack.
   int m_owner, m_last, m_hold, m_errid;
   bit m_err, m_fired;

   task automatic model_reset();
      m_owner = -1; m_last = N - 1; m_hold = 0;
      m_err = 0; m_errid = 0; m_fired = 0;
   endtask

   task automatic model_step(input logic [3:0] req, input logic fc, input logic clr);
      bit fire = 0;
      bit found = 0;
      if (m_owner >= 0) begin
         if (fc) m_hold = 0;
         else if (m_hold < TO) m_hold = m_hold + 1;
         if (!fc && m_hold == TO && !m_fired) begin
            fire = 1; m_fired = 1; m_errid = m_owner;
         end
         if (clr) m_err = 0;
         if (fire) m_err = 1;
         if (!req[m_owner]) m_owner = -1;
      end else begin
         if (clr) m_err = 0;
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (!found && req[idx]) begin
               found = 1; m_owner = idx; m_last = idx; m_hold = 0; m_fired = 0;
            end
         end
      end
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] exp_grant;
      int         exp_owner;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{4'b0001, 4'b0001, 0};
      tbl[1]  = '{4'b0001, 4'b0001, 0};
      tbl[2]  = '{4'b0000, 4'b0000, 0};
      tbl[3]  = '{4'b0000, 4'b0000, 0};
      tbl[4]  = '{4'b1010, 4'b0010, 1};
      tbl[5]  = '{4'b1010, 4'b0010, 1};
      tbl[6]  = '{4'b1001, 4'b0000, 1};
      tbl[7]  = '{4'b1001, 4'b1000, 3};
      tbl[8]  = '{4'b0001, 4'b0000, 3};
      tbl[9]  = '{4'b0001, 4'b0001, 0};
      tbl[10] = '{4'b0011, 4'b0001, 0};
      tbl[11] = '{4'b0010, 4'b0000, 0};
      tbl[12] = '{4'b0010, 4'b0010, 1};
      tbl[13] = '{4'b0000, 4'b0000, 1};
      tbl[14] = '{4'b0000, 4'b0000, 1};

      // Reset values
      repeat (3) cyc();
      chk("rst_grant", int'(bus_grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_owner", int'(owner_id), N - 1);
      chk("rst_err", int'(err), 0);
      chk("rst_err_id", int'(err_id), 0);
      @(negedge clk);
      rst = 1'b0;

      // Vector table: rotation, GAP cycles, no preemption
      for (int i = 0; i < 15; i++) begin
         bus_req = tbl[i].req;
         cyc();
         chk($sformatf("tbl%0d_grant", i), int'(bus_grant), int'(tbl[i].exp_grant));
         chk($sformatf("tbl%0d_owner", i), int'(owner_id), tbl[i].exp_owner);
         chk($sformatf("tbl%0d_busy", i), int'(busy), int'(|tbl[i].exp_grant));
         chk($sformatf("tbl%0d_err", i), int'(err), 0);
      end

      // Timeout on owner 1 with no acknowledge
      bus_req = 4'b0010;
      cyc();
      chk("to_grant_start", int'(bus_grant), 2);
      for (int i = 1; i <= TO; i++) begin
         cyc();
         chk($sformatf("to_err_c%0d", i), int'(err), (i == TO) ? 1 : 0);
      end
      chk("to_err_id", int'(err_id), 1);
      chk("to_grant_kept", int'(bus_grant), 2);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("to_clr", int'(err), 0);
      cyc();
      chk("to_once", int'(err), 0);

      // Same-cycle set and clear: set wins
      bus_req = 4'b0000;
      cyc();
      bus_req = 4'b0010;
      err_clr = 1'b1;
      cyc();
      chk("sc_grant", int'(bus_grant), 2);
      for (int i = 1; i <= TO; i++) begin
         cyc();
         chk($sformatf("sc_err_c%0d", i), int'(err), (i == TO) ? 1 : 0);
      end
      cyc();
      chk("sc_clr_after", int'(err), 0);
      err_clr = 1'b0;

      // Regular acknowledges keep the timeout away
      bus_req = 4'b0000;
      cyc();
      bus_req = 4'b0010;
      cyc();
      for (int i = 0; i < 100; i++) begin
         fc_bus = (i % 5 == 0);
         cyc();
         chk("fc_err", int'(err), 0);
      end
      fc_bus = 1'b0;
      chk("fc_grant", int'(bus_grant), 2);

      // Asynchronous reset mid-tenure
      #2;
      rst = 1'b1;
      #1;
      chk("arst_grant", int'(bus_grant), 0);
      chk("arst_busy", int'(busy), 0);
      bus_req = 4'b1010;
      @(negedge clk);
      rst = 1'b0;
      cyc();
      chk("arst_regrant", int'(bus_grant), 2);
      chk("arst_owner", int'(owner_id), 1);

      // Randomized run against the model
      bus_req = '0;
      rst = 1'b1;
      cyc();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] g;
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) bus_req[b] = ~bus_req[b];
         fc_bus  = ($urandom_range(0, 11) == 0);
         err_clr = ($urandom_range(0, 19) == 0);
         model_step(bus_req, fc_bus, err_clr);
         cyc();
         g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
         chk("rnd_grant", int'(bus_grant), int'(g));
         chk("rnd_busy", int'(busy), int'(|g));
         chk("rnd_owner", int'(owner_id), m_last);
         chk("rnd_err", int'(err), int'(m_err));
         chk("rnd_err_id", int'(err_id), m_errid);
      end

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
